// File: rtl/pcs_align_pkg.sv
// Shared definitions for 8b/10b comma alignment: K28.5 codes, aligner FSM states, window slicing.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   K28_5_RDN / K28_5_RDP : K28.5 comma in both running disparities, first-received bit at MSB
//   align_state_t         : SEARCH / CONFIRM / LOCKED
//   slice_win()           : extract Slice(k) from a {prev, current} window
package pcs_align_pkg;

   localparam int K_W = 10;

   localparam logic [K_W-1:0] K28_5_RDN = 10'b0011111010;
   localparam logic [K_W-1:0] K28_5_RDP = 10'b1100000101;

   // Widest symbol the slicing helper supports; windows are zero-extended to this.
   localparam int MAX_SYM_W = 16;

   typedef logic [2*MAX_SYM_W-1:0] win_t;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } align_state_t;

   // Slice(k) = W[2*sym_w-1-k -: sym_w]. With the window zero-extended into win_t,
   // that is simply the low sym_w bits of W >> (sym_w - k); caller truncates.
   function automatic logic [MAX_SYM_W-1:0] slice_win(input win_t        win,
                                                      input int unsigned sym_w,
                                                      input int unsigned k);
      return MAX_SYM_W'(win >> (sym_w - k));
   endfunction

endpackage

// File: rtl/pcs_comma_detect.sv
// K28.5 comma search over every bit offset of a two-word window; reports lowest matching offset.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller qualifies the result with its own valid.
//
// Ports:
//   window  : {previous word, current word}, first-received bit at MSB
//   hit     : some offset k in 0..SYM_W-1 holds a K28.5 (either disparity)
//   hit_off : lowest such k (0 when hit is low)
module pcs_comma_detect
   import pcs_align_pkg::*;
#(
   parameter int SYM_W = 10,
   parameter int OFF_W = $clog2(SYM_W)
)
(
   input  logic [2*SYM_W-1:0] window,
   output logic               hit,
   output logic [OFF_W-1:0]   hit_off
);

   logic [SYM_W-1:0] sl;

   // Scan from the highest offset down so the lowest matching offset is the last written.
   always_comb begin
      hit     = 1'b0;
      hit_off = '0;
      sl      = '0;
      for (int k = SYM_W - 1; k >= 0; k--) begin
         sl = SYM_W'(slice_win(win_t'(window), SYM_W, k));
         if (sl == SYM_W'(K28_5_RDN) || sl == SYM_W'(K28_5_RDP)) begin
            hit     = 1'b1;
            hit_off = OFF_W'(k);
         end
      end
   end

endmodule

// File: rtl/pcs_comma_aligner.sv
// 8b/10b symbol aligner: finds K28.5, locks a bit offset after LOCK_CNT consistent commas, emits aligned words.
// Latency: one cycle, Collected_Data at edge n -> all outputs registered at edge n+1.
// Backpressure: none; In_Valid low freezes all state and drops Aligned_Valid for that cycle.
//
// Ports:
//   WordClk, RST_n        : word clock; synchronous active-low reset
//   Collected_Data/In_Valid : raw PMA word (bit SYM_W-1 received first) and its qualifier
//   Aligned_Data/Aligned_Valid : word sliced at the current offset and its qualifier
//   Is_Comma              : Aligned_Data is K28.5 (either disparity), valid in every state
//   Locked / Align_Offset : alignment lock flag and current bit offset
//   Lock_Lost             : one-cycle pulse when lock is dropped by misaligned commas
//   Lock_Loss_Cnt         : saturating count of lock losses when PCS_ALIGN_STATS_EN is defined,
//                           tied to zero otherwise (port list identical in both builds)
module pcs_comma_aligner
   import pcs_align_pkg::*;
#(
   parameter int SYM_W      = 10,
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 4,
   parameter int OFF_W      = $clog2(SYM_W)
)
(
   input  logic             WordClk,
   input  logic             RST_n,
   input  logic [SYM_W-1:0] Collected_Data,
   input  logic             In_Valid,
   output logic [SYM_W-1:0] Aligned_Data,
   output logic             Aligned_Valid,
   output logic             Is_Comma,
   output logic             Locked,
   output logic [OFF_W-1:0] Align_Offset,
   output logic             Lock_Lost,
   output logic [7:0]       Lock_Loss_Cnt
);

   localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_CNT);

   align_state_t       state;
   logic [SYM_W-1:0]   prev;
   logic [OFF_W-1:0]   offset;
   logic [3:0]         cnt;
   logic [3:0]         err;

   logic [2*SYM_W-1:0] window;
   logic               hit;
   logic [OFF_W-1:0]   hit_off;
   logic [OFF_W-1:0]   off_nx;
   logic [SYM_W-1:0]   slice_nx;
   logic               comma_nx;
   logic               drop_lock;

   assign window = {prev, Collected_Data};

   pcs_comma_detect #(
      .SYM_W   (SYM_W),
      .OFF_W   (OFF_W)
   ) u_detect (
      .window  (window),
      .hit     (hit),
      .hit_off (hit_off)
   );

   // Offset being written this edge. Outside LOCKED any hit re-targets the offset
   // (a hit at the same offset rewrites the same value), so the output slice follows
   // the new offset immediately and the lock-completing comma comes out aligned.
   always_comb begin
      off_nx = offset;
      if (In_Valid && hit && state != LOCKED) begin
         off_nx = hit_off;
      end
   end

   assign slice_nx  = SYM_W'(slice_win(win_t'(window), SYM_W, 32'(off_nx)));
   assign comma_nx  = (slice_nx == SYM_W'(K28_5_RDN)) || (slice_nx == SYM_W'(K28_5_RDP));

   // Lowest-k priority already lives in hit_off, so a word carrying both an aligned and
   // a misaligned comma counts as whichever sits at the lower offset.
   assign drop_lock = In_Valid && hit && (state == LOCKED) && (hit_off != offset) &&
                      (err + 4'd1 == UNLOCK_CNT_C);

   always_ff @(posedge WordClk) begin
      if (!RST_n) begin
         state         <= SEARCH;
         prev          <= '0;
         offset        <= '0;
         cnt           <= '0;
         err           <= '0;
         Aligned_Data  <= '0;
         Aligned_Valid <= 1'b0;
         Is_Comma      <= 1'b0;
         Locked        <= 1'b0;
         Lock_Lost     <= 1'b0;
      end else begin
         Aligned_Valid <= In_Valid;
         Lock_Lost     <= drop_lock;
         if (In_Valid) begin
            prev         <= Collected_Data;
            offset       <= off_nx;
            Aligned_Data <= slice_nx;
            Is_Comma     <= comma_nx;
            if (hit) begin
               unique case (state)
                  SEARCH: begin
                     cnt <= 4'd1;
                     if (LOCK_CNT_C == 4'd1) begin
                        state  <= LOCKED;
                        Locked <= 1'b1;
                     end else begin
                        state  <= CONFIRM;
                     end
                  end
                  CONFIRM: begin
                     if (hit_off == offset) begin
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == LOCK_CNT_C) begin
                           state  <= LOCKED;
                           Locked <= 1'b1;
                        end
                     end else begin
                        // Comma at a new phase: restart the run there.
                        cnt <= 4'd1;
                     end
                  end
                  LOCKED: begin
                     if (hit_off == offset) begin
                        err <= '0;
                     end else if (drop_lock) begin
                        // Offset is kept; the next SEARCH hit overwrites it.
                        state  <= SEARCH;
                        Locked <= 1'b0;
                        err    <= '0;
                        cnt    <= '0;
                     end else begin
                        err <= err + 4'd1;
                     end
                  end
                  default: begin
                     state  <= SEARCH;
                     Locked <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign Align_Offset = offset;

`ifdef PCS_ALIGN_STATS_EN
   logic [7:0] loss_cnt;

   // Counts on the same edge that raises Lock_Lost; only reset clears it.
   always_ff @(posedge WordClk) begin
      if (!RST_n) begin
         loss_cnt <= '0;
      end else if (drop_lock && loss_cnt != 8'hFF) begin
         loss_cnt <= loss_cnt + 8'd1;
      end
   end

   assign Lock_Loss_Cnt = loss_cnt;
`else
   assign Lock_Loss_Cnt = '0;
`endif

endmodule

// File: tb/tb_pcs_comma_aligner.sv
// Self-checking bench for pcs_comma_aligner: bit-stream stimulus with commas placed at chosen phases.
// Latency: expected outputs appear one edge after each driven word.
// Backpressure: exercises In_Valid gaps.
module tb_pcs_comma_aligner;

   localparam int SYM_W      = 10;
   localparam int LOCK_CNT   = 3;
   localparam int UNLOCK_CNT = 4;
   localparam int OFF_W      = 4;

   localparam logic [9:0] RDN = 10'b0011111010;
   localparam logic [9:0] RDP = 10'b1100000101;

`ifdef PCS_ALIGN_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             WordClk = 1'b0;
   logic             RST_n   = 1'b0;
   logic [SYM_W-1:0] Collected_Data = '0;
   logic             In_Valid = 1'b0;
   logic [SYM_W-1:0] Aligned_Data;
   logic             Aligned_Valid;
   logic             Is_Comma;
   logic             Locked;
   logic [OFF_W-1:0] Align_Offset;
   logic             Lock_Lost;
   logic [7:0]       Lock_Loss_Cnt;

   always #5 WordClk = ~WordClk;

   pcs_comma_aligner #(
      .SYM_W          (SYM_W),
      .LOCK_CNT       (LOCK_CNT),
      .UNLOCK_CNT     (UNLOCK_CNT),
      .OFF_W          (OFF_W)
   ) dut (
      .WordClk        (WordClk),
      .RST_n          (RST_n),
      .Collected_Data (Collected_Data),
      .In_Valid       (In_Valid),
      .Aligned_Data   (Aligned_Data),
      .Aligned_Valid  (Aligned_Valid),
      .Is_Comma       (Is_Comma),
      .Locked         (Locked),
      .Align_Offset   (Align_Offset),
      .Lock_Lost      (Lock_Lost),
      .Lock_Loss_Cnt  (Lock_Loss_Cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Tracks: the last valid word, whether a candidate phase exists, how many commas in a
   // row sat on it, whether we are locked, and the current streak of off-phase commas.
   logic [9:0] m_prev;
   bit         m_have, m_locked;
   int         m_off, m_run, m_bad, m_losses;
   logic [9:0] e_data;
   bit         e_vld, e_comma, e_lost;

   function automatic int find_comma(input logic [9:0] p, input logic [9:0] d);
      logic [19:0] w;
      logic [9:0]  s;
      w = {p, d};
      for (int k = 0; k < 10; k++) begin
         s = 10'(w >> (10 - k));
         if (s == RDN || s == RDP) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_prev = '0; m_have = 0; m_locked = 0;
      m_off = 0; m_run = 0; m_bad = 0; m_losses = 0;
      e_data = '0; e_vld = 0; e_comma = 0; e_lost = 0;
   endtask

   task automatic model_step(input logic [9:0] d, input bit vld);
      int k;
      e_vld  = vld;
      e_lost = 0;
      if (vld) begin
         k = find_comma(m_prev, d);
         if (k >= 0) begin
            if (!m_locked) begin
               if (m_have && k == m_off) m_run++;
               else begin m_have = 1; m_off = k; m_run = 1; end
               if (m_run >= LOCK_CNT) m_locked = 1;
            end else if (k == m_off) begin
               m_bad = 0;
            end else begin
               m_bad++;
               if (m_bad >= UNLOCK_CNT) begin
                  m_locked = 0; m_have = 0; m_bad = 0;
                  e_lost = 1; m_losses++;
               end
            end
         end
         e_data  = 10'({m_prev, d} >> (10 - m_off));
         e_comma = (e_data == RDN) || (e_data == RDP);
         m_prev  = d;
      end
   endtask

   task automatic compare_all();
      int exp_cnt;
      exp_cnt = STATS ? ((m_losses > 255) ? 255 : m_losses) : 0;
      check("aligned_valid", 32'(Aligned_Valid), 32'(e_vld));
      check("aligned_data",  32'(Aligned_Data),  32'(e_data));
      check("is_comma",      32'(Is_Comma),      32'(e_comma));
      check("locked",        32'(Locked),        32'(m_locked));
      check("align_offset",  32'(Align_Offset),  32'(m_off));
      check("lock_lost",     32'(Lock_Lost),     32'(e_lost));
      check("lock_loss_cnt", 32'(Lock_Loss_Cnt), 32'(exp_cnt));
   endtask

   // ---------------- drivers ----------------
   bit bitq[$];
   int pos;

   task automatic cycle(input logic [9:0] d, input bit vld);
      @(negedge WordClk);
      Collected_Data = d;
      In_Valid       = vld;
      model_step(d, vld);
      @(posedge WordClk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge WordClk);
      RST_n = 1'b0; In_Valid = 1'b0; Collected_Data = '0;
      @(posedge WordClk);
      #1;
      check("rst_aligned_data",  32'(Aligned_Data),  32'd0);
      check("rst_aligned_valid", 32'(Aligned_Valid), 32'd0);
      check("rst_is_comma",      32'(Is_Comma),      32'd0);
      check("rst_locked",        32'(Locked),        32'd0);
      check("rst_align_offset",  32'(Align_Offset),  32'd0);
      check("rst_lock_lost",     32'(Lock_Lost),     32'd0);
      check("rst_lock_loss_cnt", 32'(Lock_Loss_Cnt), 32'd0);
      model_reset();
      bitq.delete();
      pos = 0;
      @(negedge WordClk);
      RST_n = 1'b1;
   endtask

   // Alternating filler has no run of five equal bits, so it can never form a comma.
   task automatic filler(input int n);
      for (int i = 0; i < n; i++) begin
         bitq.push_back(pos[0]);
         pos++;
      end
   endtask

   task automatic flush();
      logic [9:0] w;
      while (bitq.size() >= 10) begin
         w = '0;
         for (int i = 0; i < 10; i++) w = {w[8:0], bitq.pop_front()};
         cycle(w, 1'b1);
      end
   endtask

   // Places a comma starting at bit k of a word, then completes the following word so
   // the window holding the whole comma is the last one driven.
   task automatic comma(input int k, input bit rdp);
      logic [9:0] c;
      while (pos % 10 != k) filler(1);
      c = rdp ? RDP : RDN;
      for (int i = 9; i >= 0; i--) begin
         bitq.push_back(c[i]);
         pos++;
      end
      filler(10 - k);
      flush();
   endtask

   task automatic gap(input int words);
      filler(words * 10);
      flush();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] w;
      model_reset();
      pos = 0;

      // Non-comma stream after reset: never locks.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         do w = 10'($urandom); while (find_comma(m_prev, w) >= 0);
         cycle(w, 1'b1);
      end
      check("t1_locked", 32'(Locked), 32'd0);

      // Three commas at offset 3, one every 8 words: lock on the third.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         comma(3, i == 1);
         if (i == 1) check("t2_not_yet_locked", 32'(Locked), 32'd0);
         if (i == 2) begin
            check("t2_locked",  32'(Locked),       32'd1);
            check("t2_offset",  32'(Align_Offset), 32'd3);
            check("t2_comma",   32'(Is_Comma),     32'd1);
            check("t2_data",    32'(Aligned_Data), 32'(10'b0011111010));
         end
         gap(6);
      end

      // Offset 3 once, then 5 three times: run restarts at 5.
      do_reset();
      comma(3, 0); gap(6);
      comma(5, 1); gap(6);
      comma(5, 0);
      check("t3_not_yet_locked", 32'(Locked), 32'd0);
      gap(6);
      comma(5, 1);
      check("t3_locked", 32'(Locked),       32'd1);
      check("t3_offset", 32'(Align_Offset), 32'd5);
      check("t3_data",   32'(Aligned_Data), 32'(10'b1100000101));
      gap(6);

      // Locked at 3, four commas at 7: lock lost on the fourth.
      do_reset();
      for (int i = 0; i < 3; i++) begin comma(3, 0); gap(2); end
      for (int i = 0; i < 4; i++) begin
         comma(7, i[0]);
         if (i == 2) begin
            check("t4_still_locked", 32'(Locked),    32'd1);
            check("t4_no_pulse",     32'(Lock_Lost), 32'd0);
         end
      end
      check("t4_lock_lost",   32'(Lock_Lost),     32'd1);
      check("t4_unlocked",    32'(Locked),        32'd0);
      check("t4_loss_cnt",    32'(Lock_Loss_Cnt), STATS ? 32'd1 : 32'd0);
      gap(1);
      check("t4_pulse_ended", 32'(Lock_Lost),     32'd0);

      // Relock at 3; an aligned comma between misaligned bursts clears the error streak.
      for (int i = 0; i < 3; i++) begin comma(3, 1); gap(1); end
      check("t5_relocked", 32'(Locked), 32'd1);
      for (int i = 0; i < 3; i++) comma(7, 0);
      comma(3, 0);
      for (int i = 0; i < 3; i++) comma(7, 1);
      check("t5_still_locked", 32'(Locked),        32'd1);
      check("t5_loss_cnt",     32'(Lock_Loss_Cnt), STATS ? 32'd1 : 32'd0);
      gap(2);

      // In_Valid gap mid-CONFIRM holds state; reset while locked gives no pulse.
      do_reset();
      comma(3, 0); gap(1);
      comma(3, 1);
      for (int i = 0; i < 5; i++) cycle(10'($urandom), 1'b0);
      check("t6_gap_not_locked", 32'(Locked), 32'd0);
      comma(3, 0);
      check("t6_locked_after_gap", 32'(Locked), 32'd1);
      gap(1);
      do_reset();

      // Repeated lock/unlock to exercise counter saturation.
      for (int n = 0; n < 260; n++) begin
         for (int i = 0; i < 3; i++) comma(3, 0);
         for (int i = 0; i < 4; i++) comma(7, 1);
      end
      check("t7_loss_cnt_sat", 32'(Lock_Loss_Cnt), STATS ? 32'd255 : 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
